id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register of the 32-bit pipelined core, with an integrated load-use hazard unit.
- Captures decoded operands and control each cycle and presents the registered func and aluOp fields to the ALU controller and ALU.
- Inserts bubbles on load-use hazards, flushes on taken branches, and holds on downstream stalls.

---
 rtl/id_ex_stage_if.sv | 70 +++++++
 rtl/id_ex_stage.sv | 128 ++++++++++++
 tb/tb_id_ex_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the ID/EX register and the execute stage.
// With IDEX_PERF_EN defined it also carries the bubble/flush performance counters.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [3:0]        id_func;
  logic [1:0]        id_aluop;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_regwrite;
  logic              id_memtoreg;
  logic              id_branch;
  logic              id_alusrc;
  logic              flush;
  logic              ex_hold;

  logic              stall_out;
  logic              illegal_op;
  logic              ex_valid;
  logic [3:0]        ex_func;
  logic [1:0]        ex_aluop;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_regwrite;
  logic              ex_memtoreg;
  logic              ex_branch;
  logic              ex_alusrc;
`ifdef IDEX_PERF_EN
  logic [15:0]       bubble_cnt;
  logic [15:0]       flush_cnt;
`endif

  modport master (
    output id_valid, id_func, id_aluop, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_memread, id_memwrite, id_regwrite,
           id_memtoreg, id_branch, id_alusrc, flush, ex_hold,
    input  stall_out, illegal_op, ex_valid, ex_func, ex_aluop, ex_rs_data,
           ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_memread, ex_memwrite,
           ex_regwrite, ex_memtoreg, ex_branch, ex_alusrc
`ifdef IDEX_PERF_EN
    , input bubble_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_valid, id_func, id_aluop, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_memread, id_memwrite, id_regwrite,
           id_memtoreg, id_branch, id_alusrc, flush, ex_hold,
    output stall_out, illegal_op, ex_valid, ex_func, ex_aluop, ex_rs_data,
           ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_memread, ex_memwrite,
           ex_regwrite, ex_memtoreg, ex_branch, ex_alusrc
`ifdef IDEX_PERF_EN
    , output bubble_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold.
// Optional IDEX_PERF_EN adds saturating bubble_cnt / flush_cnt counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);
  // Handshake: decode offers an instruction with id_valid; it is accepted on an
  // edge only when stall_out is low, otherwise decode must re-present it unchanged.
  typedef struct packed {
    logic              valid;
    logic [3:0]        func;
    logic [1:0]        aluop;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic              memtoreg;
    logic              branch;
    logic              alusrc;
  } ex_t;

  ex_t  ex_q, ex_d;
  logic illegal_q, illegal_d;
  logic hz;
  logic load_hz_bubble, load_flush_bubble;

  assign hz = ex_q.valid & ex_q.memread & (ex_q.rt != '0) & bus.id_valid &
              ((ex_q.rt == bus.id_rs) | (ex_q.rt == bus.id_rt));

  // Registers are already clear in reset, but ex_hold may still be high.
  assign bus.stall_out = rst_n & (hz | bus.ex_hold);

  always_comb begin
    ex_d              = ex_q;
    illegal_d         = 1'b0;
    load_hz_bubble    = 1'b0;
    load_flush_bubble = 1'b0;
    if (bus.ex_hold) begin
      ex_d = ex_q;
    end else if (bus.flush) begin
      ex_d              = '0;
      load_flush_bubble = 1'b1;
    end else if (hz) begin
      ex_d           = '0;
      load_hz_bubble = 1'b1;
    end else if (bus.id_valid && bus.id_aluop == 2'b11) begin
      ex_d      = '0;
      illegal_d = 1'b1;
    end else if (bus.id_valid) begin
      ex_d.valid    = 1'b1;
      ex_d.func     = bus.id_func;
      ex_d.aluop    = bus.id_aluop;
      ex_d.rs_data  = bus.id_rs_data;
      ex_d.rt_data  = bus.id_rt_data;
      ex_d.imm      = bus.id_imm;
      ex_d.rs       = bus.id_rs;
      ex_d.rt       = bus.id_rt;
      ex_d.rd       = bus.id_rd;
      ex_d.memread  = bus.id_memread;
      ex_d.memwrite = bus.id_memwrite;
      ex_d.regwrite = bus.id_regwrite;
      ex_d.memtoreg = bus.id_memtoreg;
      ex_d.branch   = bus.id_branch;
      ex_d.alusrc   = bus.id_alusrc;
    end else begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.illegal_op  = illegal_q;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_func     = ex_q.func;
  assign bus.ex_aluop    = ex_q.aluop;
  assign bus.ex_rs_data  = ex_q.rs_data;
  assign bus.ex_rt_data  = ex_q.rt_data;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_rs       = ex_q.rs;
  assign bus.ex_rt       = ex_q.rt;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_memread  = ex_q.memread;
  assign bus.ex_memwrite = ex_q.memwrite;
  assign bus.ex_regwrite = ex_q.regwrite;
  assign bus.ex_memtoreg = ex_q.memtoreg;
  assign bus.ex_branch   = ex_q.branch;
  assign bus.ex_alusrc   = ex_q.alusrc;

`ifdef IDEX_PERF_EN
  logic [15:0] bubble_cnt_q, flush_cnt_q;

  // The bubble strobes are already gated by ex_hold through the priority chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (load_hz_bubble && bubble_cnt_q != 16'hFFFF)
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
      if (load_flush_bubble && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
`else
  logic unused_strobes;
  assign unused_strobes = load_hz_bubble ^ load_flush_bubble;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: pass-through, load-use bubble,
// flush, hold, illegal aluop and asynchronous reset mid-hazard.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [DATA_W-1:0] exp_q[$];

  id_ex_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctrl = {memread, memwrite, regwrite, memtoreg, branch, alusrc}
  task automatic drive_id(input logic valid, input logic [1:0] aluop, input logic [3:0] func,
                          input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                          input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] rs_data,
                          input logic [DATA_W-1:0] rt_data, input logic [DATA_W-1:0] imm,
                          input logic [5:0] ctrl);
    bus.id_valid    = valid;
    bus.id_aluop    = aluop;
    bus.id_func     = func;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rd;
    bus.id_rs_data  = rs_data;
    bus.id_rt_data  = rt_data;
    bus.id_imm      = imm;
    bus.id_memread  = ctrl[5];
    bus.id_memwrite = ctrl[4];
    bus.id_regwrite = ctrl[3];
    bus.id_memtoreg = ctrl[2];
    bus.id_branch   = ctrl[1];
    bus.id_alusrc   = ctrl[0];
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.flush   = 1'b0;
    bus.ex_hold = 1'b1;
    drive_id(1'b0, 2'b00, 4'h0, '0, '0, '0, '0, '0, '0, 6'b0);
    #2;
    // Reset state, with ex_hold high to show stall_out stays low in reset
    check("rst_valid", bus.ex_valid, 0);
    check("rst_aluop", bus.ex_aluop, 0);
    check("rst_rs_data", bus.ex_rs_data, 0);
    check("rst_stall", bus.stall_out, 0);
    check("rst_illegal", bus.illegal_op, 0);
`ifdef IDEX_PERF_EN
    check("rst_bubble_cnt", bus.bubble_cnt, 0);
    check("rst_flush_cnt", bus.flush_cnt, 0);
`endif
    tick();
    rst_n       = 1'b1;
    bus.ex_hold = 1'b0;

    // Plain R-type pass-through
    drive_id(1'b1, 2'b01, 4'b0001, 5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 32'd9, 6'b001000);
    tick();
    check("rt_valid", bus.ex_valid, 1);
    check("rt_aluop", bus.ex_aluop, 2'b01);
    check("rt_func", bus.ex_func, 4'b0001);
    check("rt_rs_data", bus.ex_rs_data, 5);
    check("rt_rt_data", bus.ex_rt_data, 3);
    check("rt_rd", bus.ex_rd, 3);
    check("rt_regwrite", bus.ex_regwrite, 1);
    check("rt_stall", bus.stall_out, 0);

    // Load into r7, then a dependent instruction reading r7
    drive_id(1'b1, 2'b00, 4'h0, 5'd1, 5'd7, 5'd0, 32'h100, 32'h0, 32'd4, 6'b101101);
    tick();
    check("ld_memread", bus.ex_memread, 1);
    check("ld_rt", bus.ex_rt, 7);
    drive_id(1'b1, 2'b01, 4'b0010, 5'd7, 5'd2, 5'd4, 32'h11, 32'h22, 32'h0, 6'b001000);
    #1;
    check("hz_stall", bus.stall_out, 1);
    tick();
    check("hz_bubble_valid", bus.ex_valid, 0);
    check("hz_bubble_memread", bus.ex_memread, 0);
    check("hz_stall_clear", bus.stall_out, 0);
`ifdef IDEX_PERF_EN
    check("hz_bubble_cnt", bus.bubble_cnt, 1);
`endif
    tick();
    check("hz_dep_valid", bus.ex_valid, 1);
    check("hz_dep_rs", bus.ex_rs, 7);
    check("hz_dep_func", bus.ex_func, 4'b0010);

    // Load into r0 never stalls
    drive_id(1'b1, 2'b00, 4'h0, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'd8, 6'b101101);
    tick();
    drive_id(1'b1, 2'b01, 4'b0011, 5'd0, 5'd0, 5'd6, 32'h33, 32'h44, 32'h0, 6'b001000);
    #1;
    check("r0_stall", bus.stall_out, 0);
    tick();
    check("r0_valid", bus.ex_valid, 1);
    check("r0_func", bus.ex_func, 4'b0011);

    // Flush a valid R-type
    bus.flush = 1'b1;
    drive_id(1'b1, 2'b01, 4'b0100, 5'd2, 5'd3, 5'd8, 32'h55, 32'h66, 32'h0, 6'b001000);
    tick();
    check("fl_valid", bus.ex_valid, 0);
    check("fl_regwrite", bus.ex_regwrite, 0);
    check("fl_func", bus.ex_func, 0);
`ifdef IDEX_PERF_EN
    check("fl_flush_cnt", bus.flush_cnt, 1);
`endif

    // Hold for three edges with flush pending
    bus.flush = 1'b0;
    drive_id(1'b1, 2'b01, 4'b0101, 5'd2, 5'd3, 5'd5, 32'hAA, 32'h0, 32'h0, 6'b001000);
    tick();
    check("pre_hold_rs_data", bus.ex_rs_data, 32'hAA);
    bus.ex_hold = 1'b1;
    bus.flush   = 1'b1;
    drive_id(1'b1, 2'b01, 4'b0110, 5'd2, 5'd3, 5'd9, 32'hBB, 32'h0, 32'h0, 6'b001000);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_stall", bus.stall_out, 1);
      tick();
      check("hold_rs_data", bus.ex_rs_data, 32'hAA);
      check("hold_valid", bus.ex_valid, 1);
      check("hold_rd", bus.ex_rd, 5);
    end
`ifdef IDEX_PERF_EN
    check("hold_flush_cnt", bus.flush_cnt, 1);
`endif
    bus.ex_hold = 1'b0;
    #1;
    check("unhold_stall", bus.stall_out, 0);
    tick();
    check("unhold_bubble", bus.ex_valid, 0);
`ifdef IDEX_PERF_EN
    check("unhold_flush_cnt", bus.flush_cnt, 2);
`endif
    bus.flush = 1'b0;

    // Back-to-back throughput through the expected queue
    for (int i = 0; i < 4; i++) begin
      drive_id(1'b1, 2'b01, 4'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3),
               32'h10 + 32'(i), 32'h0, 32'h0, 6'b001000);
      exp_q.push_back(32'h10 + 32'(i));
      tick();
      check("tp_rs_data", bus.ex_rs_data, exp_q.pop_front());
      check("tp_valid", bus.ex_valid, 1);
    end

    // Reserved aluop
    drive_id(1'b1, 2'b11, 4'b0111, 5'd1, 5'd2, 5'd3, 32'h77, 32'h0, 32'h0, 6'b001000);
    tick();
    check("ill_pulse", bus.illegal_op, 1);
    check("ill_valid", bus.ex_valid, 0);
    check("ill_aluop", bus.ex_aluop, 0);
    drive_id(1'b1, 2'b01, 4'b1000, 5'd1, 5'd2, 5'd3, 32'h88, 32'h0, 32'h0, 6'b001000);
    tick();
    check("ill_drop", bus.illegal_op, 0);
    check("ill_next_valid", bus.ex_valid, 1);

    // Asynchronous reset in the middle of a load-use stall
    drive_id(1'b1, 2'b00, 4'h0, 5'd1, 5'd7, 5'd0, 32'h0, 32'h0, 32'd4, 6'b101101);
    tick();
    drive_id(1'b1, 2'b01, 4'b0001, 5'd7, 5'd2, 5'd4, 32'h0, 32'h0, 32'h0, 6'b001000);
    #1;
    check("mid_stall", bus.stall_out, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.ex_valid, 0);
    check("mid_rst_memread", bus.ex_memread, 0);
    check("mid_rst_rt", bus.ex_rt, 0);
    check("mid_rst_stall", bus.stall_out, 0);
`ifdef IDEX_PERF_EN
    check("mid_rst_bubble_cnt", bus.bubble_cnt, 0);
`endif
    tick();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
